mem_io_responder: RTL and testbench

- Responder end of the CPU memory interface: services MREAD/MWRITE commands issued by the controller FSM on mem_cmd/mem_addr.
- Holds the instruction/data RAM and a small memory-mapped I/O window (switches in, LEDs out).
- Read latency is programmable, with completion signalled by a one-cycle mem_ready pulse.
- Sits between the datapath/controller and board I/O in the top level.

---
 rtl/mem_io_responder.sv | 142 ++++++++++++++
 tb/tb_mem_io_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Responder end of the CPU memory interface: RAM, switch/LED I/O window,
// programmable read latency and a one-cycle mem_ready completion pulse.
module mem_io_responder #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 9,
  parameter int unsigned       RAM_AW   = 8,
  parameter int unsigned       RD_LAT   = 2,
  parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140,
  parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              busy,
  input  logic [7:0]        SW,
  output logic [7:0]        LEDR,
  output logic              err
);

  localparam int unsigned CNT_W     = 3;
  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr_q;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  ram [RAM_DEPTH];

  logic [ADDR_W-1:0]  rd_addr_c;
  logic               rd_in_ram_c;
  logic               wr_in_ram_c;
  logic               rd_bad_c;
  logic [DATA_W-1:0]  rd_word_c;
  logic               ram_we_c;

  // Read source decode; in IDLE the live address is used so a 1-cycle read
  // can load read_data on its accept edge.
  always_comb begin
    rd_addr_c   = (state == IDLE) ? mem_addr : addr_q;
    rd_in_ram_c = (rd_addr_c[ADDR_W-1:RAM_AW] == '0);
    wr_in_ram_c = (mem_addr[ADDR_W-1:RAM_AW] == '0);
    rd_word_c   = '0;
    rd_bad_c    = 1'b0;
    if (rd_in_ram_c) begin
      rd_word_c = ram[rd_addr_c[RAM_AW-1:0]];
    end else if (rd_addr_c == SW_ADDR) begin
      rd_word_c = DATA_W'(SW);
    end else begin
      rd_bad_c = 1'b1;
    end
    ram_we_c = !reset && (state == IDLE) && (mem_cmd == CMD_WRITE) && wr_in_ram_c;
  end

  // RAM array carries no reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      ram[mem_addr[RAM_AW-1:0]] <= write_data;
    end
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      cnt       <= '0;
      read_data <= '0;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      LEDR      <= '0;
      err       <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          case (mem_cmd)
            CMD_READ: begin
              addr_q <= mem_addr;
              cnt    <= CNT_W'(RD_LAT - 1);
              if (RD_LAT == 1) begin
                state     <= DONE;
                mem_ready <= 1'b1;
                read_data <= rd_word_c;
                if (rd_bad_c) err <= 1'b1;
              end else begin
                state <= RD_WAIT;
                busy  <= 1'b1;
              end
            end
            CMD_WRITE: begin
              state     <= DONE;
              mem_ready <= 1'b1;
              if (mem_addr == LED_ADDR) begin
                LEDR <= write_data[7:0];
              end else if (!wr_in_ram_c) begin
                err <= 1'b1;
              end
            end
            CMD_NONE: begin
              state <= IDLE;
            end
            default: begin
              err <= 1'b1;
            end
          endcase
        end
        RD_WAIT: begin
          if (cnt <= CNT_W'(1)) begin
            state     <= DONE;
            cnt       <= '0;
            busy      <= 1'b0;
            mem_ready <= 1'b1;
            read_data <= rd_word_c;
            if (rd_bad_c) err <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboarded bench for mem_io_responder (RD_LAT=2 main instance, RD_LAT=1 side instance).
module tb_mem_io_responder;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b11;
  localparam logic [1:0] MILL   = 2'b10;
  localparam int         LAT    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        mem_ready;
  logic        busy;
  logic [7:0]  SW;
  logic [7:0]  LEDR;
  logic        err;

  logic [1:0]  cmd1;
  logic [8:0]  addr1;
  logic [15:0] wd1;
  logic [15:0] read_data1;
  logic        mem_ready1;
  logic        busy1;
  logic [7:0]  ledr1;
  logic        err1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_io_responder #(.RD_LAT(2)) dut (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .read_data(read_data), .mem_ready(mem_ready),
    .busy(busy), .SW(SW), .LEDR(LEDR), .err(err)
  );

  mem_io_responder #(.RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .mem_cmd(cmd1), .mem_addr(addr1),
    .write_data(wd1), .read_data(read_data1), .mem_ready(mem_ready1),
    .busy(busy1), .SW(SW), .LEDR(ledr1), .err(err1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every mem_ready pulse must match the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (mem_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got pulse at cycle %0d expected none", cyc);
      end else begin
        e = sbq.pop_front();
        check("ready_cycle", cyc, e.cyc);
        check("read_data", {16'h0, read_data}, {16'h0, e.data});
        check("err_at_ready", {31'h0, err}, {31'h0, e.err});
      end
    end
  end

  // Issue one command on the main instance; called at posedge+1.
  task automatic issue(input logic [1:0] cmd, input logic [8:0] a, input logic [15:0] wd,
                       input logic [15:0] exp_data, input logic exp_err);
    exp_t e;
    int   gap;
    mem_cmd    = cmd;
    mem_addr   = a;
    write_data = wd;
    e.cyc  = (cmd == MREAD) ? cyc + LAT : cyc + 1;
    e.data = exp_data;
    e.err  = exp_err;
    sbq.push_back(e);
    gap = (cmd == MREAD) ? LAT + 1 : 2;
    @(posedge clk); #1;
    mem_cmd = MNONE;
    if (cmd == MREAD) check("busy_in_flight", {31'h0, busy}, 32'h1);
    repeat (gap - 1) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [8:0] a, input logic [15:0] wd, input logic [15:0] exp_data,
                    input logic exp_err);
    issue(MWRITE, a, wd, exp_data, exp_err);
  endtask

  task automatic rd(input logic [8:0] a, input logic [15:0] exp_data, input logic exp_err);
    issue(MREAD, a, 16'h0, exp_data, exp_err);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   k;
    reset = 1'b1; mem_cmd = MNONE; mem_addr = '0; write_data = '0; SW = '0;
    cmd1 = MNONE; addr1 = '0; wd1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read_data", {16'h0, read_data}, 32'h0);
    check("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_ledr", {24'h0, LEDR}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // RAM write then read back
    wr(9'h005, 16'hBEEF, 16'h0000, 1'b0);
    rd(9'h005, 16'hBEEF, 1'b0);

    // Switch read, LED write leaves read_data untouched
    SW = 8'hA5;
    rd(9'h140, 16'h00A5, 1'b0);
    wr(9'h100, 16'h1234, 16'h00A5, 1'b0);
    check("ledr_after_write", {24'h0, LEDR}, 32'h34);
    check("read_data_hold", {16'h0, read_data}, 32'h00A5);
    wr(9'h010, 16'h0042, 16'h00A5, 1'b0);

    // Unmapped read sets sticky err; reset clears it
    rd(9'h1F0, 16'h0000, 1'b1);
    rd(9'h010, 16'h0042, 1'b1);
    pulse_reset();
    check("err_cleared", {31'h0, err}, 32'h0);
    check("rst2_read_data", {16'h0, read_data}, 32'h0);
    check("rst2_ledr", {24'h0, LEDR}, 32'h0);

    // Write presented during reset must not commit
    wr(9'h007, 16'h1111, 16'h0000, 1'b0);
    reset = 1'b1; mem_cmd = MWRITE; mem_addr = 9'h007; write_data = 16'hDEAD;
    @(posedge clk); #1;
    reset = 1'b0; mem_cmd = MNONE;
    rd(9'h007, 16'h1111, 1'b0);

    // Reset during RD_WAIT aborts the read
    mem_cmd = MREAD; mem_addr = 9'h005;
    @(posedge clk); #1;
    mem_cmd = MNONE;
    check("abort_busy_before", {31'h0, busy}, 32'h1);
    pulse_reset();
    check("abort_mem_ready", {31'h0, mem_ready}, 32'h0);
    check("abort_read_data", {16'h0, read_data}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rd(9'h005, 16'hBEEF, 1'b0);

    // Held MREAD: fresh transaction every RD_LAT+1 cycles
    k = cyc;
    mem_cmd = MREAD; mem_addr = 9'h010;
    e.data = 16'h0042; e.err = 1'b0;
    e.cyc = k + 2; sbq.push_back(e);
    e.cyc = k + 5; sbq.push_back(e);
    e.cyc = k + 8; sbq.push_back(e);
    repeat (9) @(posedge clk);
    #1;
    mem_cmd = MNONE;
    @(posedge clk); #1;

    // Illegal command: no completion, no RAM/LED change, err set
    wr(9'h100, 16'h00C3, 16'h0042, 1'b0);
    check("ledr_c3", {24'h0, LEDR}, 32'hC3);
    mem_cmd = MILL; mem_addr = 9'h100; write_data = 16'h0055;
    @(posedge clk); #1;
    mem_cmd = MNONE;
    check("illegal_err", {31'h0, err}, 32'h1);
    check("illegal_ledr", {24'h0, LEDR}, 32'hC3);
    mem_cmd = MILL; mem_addr = 9'h010; write_data = 16'h9999;
    @(posedge clk); #1;
    mem_cmd = MNONE;
    @(posedge clk); #1;
    rd(9'h010, 16'h0042, 1'b1);

    // Write to the read-only switch address is an error
    pulse_reset();
    wr(9'h140, 16'h7777, 16'h0000, 1'b1);
    check("sw_write_ledr", {24'h0, LEDR}, 32'h0);

    // RD_LAT=1 instance: ready on the cycle right after accept
    cmd1 = MWRITE; addr1 = 9'h003; wd1 = 16'h0077;
    @(posedge clk); #1;
    cmd1 = MNONE;
    check("lat1_wr_ready", {31'h0, mem_ready1}, 32'h1);
    @(posedge clk); #1;
    check("lat1_wr_ready_low", {31'h0, mem_ready1}, 32'h0);
    cmd1 = MREAD; addr1 = 9'h003;
    @(posedge clk); #1;
    cmd1 = MNONE;
    check("lat1_rd_ready", {31'h0, mem_ready1}, 32'h1);
    check("lat1_rd_data", {16'h0, read_data1}, 32'h0077);
    check("lat1_busy", {31'h0, busy1}, 32'h0);
    @(posedge clk); #1;
    check("lat1_rd_ready_low", {31'h0, mem_ready1}, 32'h0);
    check("lat1_err", {31'h0, err1}, 32'h0);

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", sbq.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
